mc_ctrl_unit: RTL

//  Multi-cycle control FSM that drives the 32-bit ALU and the rest of the datapath.

---
 rtl/mc_ctrl_pkg.sv | 102 ++++++++++
 rtl/mc_ctrl_unit_alu_op_decode.sv | 56 +++++
 rtl/mc_ctrl_unit.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle control unit: state encoding, ALU op
// codes, instruction field constants and small decode helpers.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IF = 4'd0,
    ST_ID = 4'd1,
    ST_MA = 4'd2,
    ST_MR = 4'd3,
    ST_MW = 4'd4,
    ST_SW = 4'd5,
    ST_RX = 4'd6,
    ST_RW = 4'd7,
    ST_IX = 4'd8,
    ST_IW = 4'd9,
    ST_BR = 4'd10,
    ST_JP = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_XOR = 3'b011,
    ALU_NOR = 3'b100,
    ALU_SRL = 3'b101,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_t;

  // What the ALU is being used for in a given state.
  typedef enum logic [1:0] {
    CLS_ADD   = 2'd0,
    CLS_RTYPE = 2'd1,
    CLS_ITYPE = 2'd2,
    CLS_SUB   = 2'd3
  } op_class_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam int N_RFN = 8;
  localparam logic [5:0] RFN_CODE [N_RFN] = '{
    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SRL
  };
  localparam alu_op_t RFN_OP [N_RFN] = '{
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SRL
  };

  localparam int N_IOP = 5;
  localparam logic [5:0] IOP_CODE [N_IOP] = '{
    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI
  };
  localparam alu_op_t IOP_OP [N_IOP] = '{
    ALU_ADD, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT
  };

  // Decode-stage dispatch; ST_IF marks an opcode the machine does not implement.
  function automatic state_t dispatch(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW:                                return ST_MA;
      OP_RTYPE:                                    return ST_RX;
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI:  return ST_IX;
      OP_BEQ, OP_BNE:                              return ST_BR;
      OP_J:                                        return ST_JP;
      default:                                     return ST_IF;
    endcase
  endfunction

  function automatic op_class_t state_class(input state_t s);
    case (s)
      ST_RX:   return CLS_RTYPE;
      ST_IX:   return CLS_ITYPE;
      ST_BR:   return CLS_SUB;
      default: return CLS_ADD;
    endcase
  endfunction

  // Logical immediates take a zero-extended operand.
  function automatic logic is_zext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/mc_ctrl_unit_alu_op_decode.sv
// Combinational ALU operation decoder: picks the op for the current state class
// from funct (R-type) or opcode (immediate), flagging unknown encodings.
module alu_op_decode
  import mc_ctrl_pkg::*;
(
  input  op_class_t   op_class,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  output alu_op_t     alu_op,
  output logic        illegal
);

  logic [N_RFN-1:0] rfn_hit;
  logic [N_IOP-1:0] iop_hit;
  alu_op_t          r_op;
  alu_op_t          i_op;

  genvar gi;
  generate
    for (gi = 0; gi < N_RFN; gi++) begin : g_rfn
      assign rfn_hit[gi] = (funct == RFN_CODE[gi]);
    end
    for (gi = 0; gi < N_IOP; gi++) begin : g_iop
      assign iop_hit[gi] = (opcode == IOP_CODE[gi]);
    end
  endgenerate

  always_comb begin
    r_op = ALU_ADD;
    i_op = ALU_ADD;
    for (int i = 0; i < N_RFN; i++) begin
      if (rfn_hit[i]) r_op = RFN_OP[i];
    end
    for (int i = 0; i < N_IOP; i++) begin
      if (iop_hit[i]) i_op = IOP_OP[i];
    end
  end

  always_comb begin
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    case (op_class)
      CLS_RTYPE: begin
        alu_op  = r_op;
        illegal = ~|rfn_hit;
      end
      CLS_ITYPE: begin
        alu_op  = i_op;
        illegal = ~|iop_hit;
      end
      CLS_SUB: alu_op = ALU_SUB;
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_unit.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/write-back and
// drives the datapath selects, ALU op, memory handshake and exception pulses.
module mc_ctrl_unit
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        overflow,
  input  logic        mem_ready,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_we,
  output logic [1:0]  pc_source,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        ext_zero,
  output logic [2:0]  alu_operation,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        ovf_exc,
  output logic        illegal,
  output logic        bus_err,
  output logic [3:0]  state
);

  // Largest value held is MEM_TIMEOUT-1.
  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               ovf_exc_reg;
  logic               illegal_reg;
  logic               bus_err_reg;

  op_class_t          cur_class;
  alu_op_t            dec_op;
  logic               dec_illegal;
  logic               mem_wait;
  logic               timeout_hit;
  logic               ovf_check;

  assign cur_class = state_class(state_reg);

  alu_op_decode u_alu_op_decode (
    .op_class (cur_class),
    .opcode   (opcode),
    .funct    (funct),
    .alu_op   (dec_op),
    .illegal  (dec_illegal)
  );

  assign mem_wait    = ((state_reg == ST_IF) || (state_reg == ST_MR) || (state_reg == ST_SW))
                       && !mem_ready;
  assign timeout_hit = (MEM_TIMEOUT != 0) && (32'(cnt_reg) == MEM_TIMEOUT - 32'd1);
  // Only signed arithmetic traps; logical ops and slt ignore the flag.
  assign ovf_check   = ((state_reg == ST_RX) && ((funct == FN_ADD) || (funct == FN_SUB)))
                       || ((state_reg == ST_IX) && (opcode == OP_ADDI));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IF;
      cnt_reg     <= '0;
      ovf_exc_reg <= 1'b0;
      illegal_reg <= 1'b0;
      bus_err_reg <= 1'b0;
    end else begin
      ovf_exc_reg <= 1'b0;
      illegal_reg <= 1'b0;
      bus_err_reg <= 1'b0;
      cnt_reg     <= '0;
      if (mem_wait) begin
        if (timeout_hit) begin
          bus_err_reg <= 1'b1;
          state_reg   <= ST_IF;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end else begin
        case (state_reg)
          ST_IF: state_reg <= ST_ID;
          ST_ID: begin
            state_reg   <= dispatch(opcode);
            illegal_reg <= (dispatch(opcode) == ST_IF);
          end
          ST_MA: state_reg <= (opcode == OP_SW) ? ST_SW : ST_MR;
          ST_MR: state_reg <= ST_MW;
          ST_RX, ST_IX: begin
            if (dec_illegal) begin
              illegal_reg <= 1'b1;
              state_reg   <= ST_IF;
            end else if (ovf_check && overflow) begin
              ovf_exc_reg <= 1'b1;
              state_reg   <= ST_IF;
            end else begin
              state_reg <= (state_reg == ST_RX) ? ST_RW : ST_IW;
            end
          end
          default: state_reg <= ST_IF;
        endcase
      end
    end
  end

  // Moore decode; pc_we/ir_write additionally qualified by mem_ready or zero.
  always_comb begin
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_we      = 1'b0;
    pc_source  = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    ext_zero   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    case (state_reg)
      ST_IF: begin
        mem_rd    = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_we     = mem_ready;
      end
      ST_ID: alu_src_b = 2'b11;
      ST_MA: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ST_MR: begin
        mem_rd = 1'b1;
        iord   = 1'b1;
      end
      ST_SW: begin
        mem_wr = 1'b1;
        iord   = 1'b1;
      end
      ST_MW: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_RX: alu_src_a = 1'b1;
      ST_RW: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      ST_IX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ext_zero  = is_zext(opcode);
      end
      ST_IW: reg_write = 1'b1;
      ST_BR: begin
        alu_src_a = 1'b1;
        pc_source = 2'b01;
        pc_we     = (opcode == OP_BNE) ? !zero : zero;
      end
      ST_JP: begin
        pc_source = 2'b10;
        pc_we     = 1'b1;
      end
      default: ;
    endcase
  end

  assign alu_operation = dec_op;
  assign ovf_exc       = ovf_exc_reg;
  assign illegal       = illegal_reg;
  assign bus_err       = bus_err_reg;
  assign state         = state_reg;

endmodule
